// File: rtl/dbus_pkg.sv
// Shared bus widths and FSM encoding for the data-bus SRAM responder.
package dbus_pkg;

  localparam int DBUS_ADDR_W = 32;
  localparam int DBUS_DATA_W = 32;
  localparam int DBUS_SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dbus_state_e;

endpackage

// File: rtl/sram_bytewe.sv
// Single-port SRAM, synchronous read, per-byte-lane write enables. Contents are not reset.
module sram_bytewe
  import dbus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_en,
  input  logic                   i_we,
  input  logic [DBUS_SEL_W-1:0]  i_sel,
  input  logic [AW-1:0]          i_addr,
  input  logic [DBUS_DATA_W-1:0] i_wdata,
  output logic [DBUS_DATA_W-1:0] o_rdata
);

  logic [DBUS_DATA_W-1:0] r_mem [DEPTH];

  // A write leaves o_rdata untouched so the last read word stays visible.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int k = 0; k < DBUS_SEL_W; k++) begin
          if (i_sel[k]) r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
        end
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/dbus_sram.sv
// Data-bus responder: one request at a time, fixed latency, byte-masked stores,
// full-word loads, error acknowledge for addresses outside the SRAM window.
module dbus_sram
  import dbus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   dbus_req_i,
  input  logic                   dbus_we_i,
  input  logic [DBUS_ADDR_W-1:0] dbus_addr_i,
  input  logic [DBUS_DATA_W-1:0] dbus_data_i,
  input  logic [DBUS_SEL_W-1:0]  dbus_sel_i,
  output logic [DBUS_DATA_W-1:0] dbus_data_o,
  output logic                   dbus_ack_o,
  output logic                   dbus_err_o,
  output dbus_state_e            dbg_state_o
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  CNT_INIT  = 4'(LATENCY - 1);

  // Handshake: dbus_req_i is sampled only in IDLE; the initiator holds it and
  // all fields stable until dbus_ack_o, which is a one-cycle pulse qualified by
  // dbus_err_o. Field changes after acceptance are ignored.

  dbus_state_e r_state, w_state_nxt;
  logic [3:0]             r_cnt;
  logic                   r_we, r_hit, r_ack, r_err;
  logic [IDX_W-1:0]       r_idx;
  logic [DBUS_DATA_W-1:0] r_wdata, r_dout;
  logic [DBUS_SEL_W-1:0]  r_sel;

  logic [DBUS_ADDR_W-1:0] w_off;
  logic                   w_hit, w_accept, w_issue, w_use_in;
  logic [IDX_W-1:0]       w_idx;
  logic                   w_m_we, w_m_hit, w_mem_en;
  logic [IDX_W-1:0]       w_m_idx;
  logic [DBUS_DATA_W-1:0] w_m_wdata, w_rdata;
  logic [DBUS_SEL_W-1:0]  w_m_sel;

  assign w_off = dbus_addr_i - BASE_ADDR;
  assign w_hit = (w_off < WIN_BYTES);
  assign w_idx = IDX_W'(w_off >> 2);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (dbus_req_i) begin
          w_accept    = 1'b1;
          w_state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY:    if (r_cnt == 4'd1) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The SRAM is driven on the edge entering RESP; with LATENCY=1 that edge is
  // also the acceptance edge, so the live bus fields are used instead of the
  // latched copies.
  assign w_issue   = (w_state_nxt == RESP) && (r_state != RESP);
  assign w_use_in  = (r_state == IDLE);
  assign w_m_we    = w_use_in ? dbus_we_i   : r_we;
  assign w_m_hit   = w_use_in ? w_hit       : r_hit;
  assign w_m_idx   = w_use_in ? w_idx       : r_idx;
  assign w_m_wdata = w_use_in ? dbus_data_i : r_wdata;
  assign w_m_sel   = w_use_in ? dbus_sel_i  : r_sel;
  assign w_mem_en  = w_issue && w_m_hit;

  sram_bytewe #(
    .DEPTH (DEPTH_WORDS),
    .AW    (IDX_W)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (w_m_we),
    .i_sel   (w_m_sel),
    .i_addr  (w_m_idx),
    .i_wdata (w_m_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_hit   <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= dbus_we_i;
        r_hit   <= w_hit;
        r_idx   <= w_idx;
        r_wdata <= dbus_data_i;
        r_sel   <= dbus_sel_i;
        r_cnt   <= CNT_INIT;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= 4'(r_cnt - 4'd1);
      end
      r_ack <= w_issue;
      r_err <= w_issue && !w_m_hit;
      // Completed loads refresh the held word; a missed load holds zero.
      if (r_state == RESP && !r_we) r_dout <= r_hit ? w_rdata : '0;
    end
  end

  always_comb begin
    dbus_data_o = r_dout;
    if (r_state == RESP) begin
      if (!r_hit)    dbus_data_o = '0;
      else if (!r_we) dbus_data_o = w_rdata;
    end
  end

  assign dbus_ack_o  = r_ack;
  assign dbus_err_o  = r_err;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_dbus_sram.sv
// Self-checking bench for dbus_sram: directed vector table, hand-written
// back-to-back and reset-abort sequences, and randomized traffic against a model.
module tb_dbus_sram
  import dbus_pkg::*;
#(
  parameter int LATENCY = 2
);

  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] WIN   = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  sel = '0;
  logic [31:0] rdata;
  logic        ack, err;
  dbus_state_e dbg_state;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] ref_mem [int unsigned];

  dbus_sram #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LATENCY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dbus_req_i  (req),
    .dbus_we_i   (we),
    .dbus_addr_i (addr),
    .dbus_data_i (wdata),
    .dbus_sel_i  (sel),
    .dbus_data_o (rdata),
    .dbus_ack_o  (ack),
    .dbus_err_o  (err),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One access: fields driven at a falling edge, held until the ack, then dropped.
  task automatic access(input logic a_we, input logic [31:0] a_addr, input logic [31:0] a_data,
                        input logic [3:0] a_sel, output logic [31:0] o_data, output logic o_err);
    int  lat;
    bit  seen;
    @(negedge clk);
    we = a_we; addr = a_addr; wdata = a_data; sel = a_sel; req = 1'b1;
    lat = 0; seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack) begin
        seen = 1;
        break;
      end
      chk("err_without_ack", {31'd0, err}, 32'd0);
      // Latched copies must be used once the request has been accepted.
      we = ~we; addr = $urandom; wdata = $urandom; sel = 4'($urandom_range(0, 15));
    end
    o_data = rdata;
    o_err  = err;
    req = 1'b0;
    chk("ack_seen", {31'd0, seen}, 32'd1);
    chk("ack_latency", lat, LATENCY);
    @(negedge clk);
    chk("ack_width", {31'd0, ack}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic        exp_err;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_exp [3];
    int          cyc, k;
    logic        prev_ack;

    vecs[0] = '{"st_full",      1'b1, BASE + 32'h10,  32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{"ld_full",      1'b0, BASE + 32'h10,  32'h0,         4'b0000, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{"st_lane1",     1'b1, BASE + 32'h10,  32'h0000_AA00, 4'b0010, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{"ld_merged",    1'b0, BASE + 32'h10,  32'h0,         4'b1111, 1'b0, 1'b1, 32'hDEAD_AAEF};
    vecs[4] = '{"st_last",      1'b1, BASE + WIN - 4, 32'h1234_5678, 4'b1111, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{"ld_below",     1'b0, 32'h7FFF_FFFC,  32'h0,         4'b1111, 1'b1, 1'b1, 32'h0};
    vecs[6] = '{"st_above",     1'b1, BASE + WIN,     32'hABCD_ABCD, 4'b1111, 1'b1, 1'b1, 32'h0};
    vecs[7] = '{"ld_last",      1'b0, BASE + WIN - 4, 32'h0,         4'b0000, 1'b0, 1'b1, 32'h1234_5678};
    vecs[8] = '{"st_sel0",      1'b1, BASE + 32'h10,  32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b0, 32'h0};
    vecs[9] = '{"ld_unaligned", 1'b0, BASE + 32'h13,  32'h0,         4'b0000, 1'b0, 1'b1, 32'hDEAD_AAEF};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ack",   {31'd0, ack}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_data",  rdata, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sel, d, e);
      chk({vecs[i].name, "_err"}, {31'd0, e}, {31'd0, vecs[i].exp_err});
      if (vecs[i].chk_data) chk({vecs[i].name, "_data"}, d, vecs[i].exp_data);
    end

    // Back-to-back loads with the request held high across acks
    b2b_addr = '{BASE + 32'h10, BASE + WIN - 4, BASE + 32'h10};
    b2b_exp  = '{32'hDEAD_AAEF, 32'h1234_5678, 32'hDEAD_AAEF};
    @(negedge clk);
    we = 1'b0; sel = 4'b0000; addr = b2b_addr[0]; req = 1'b1;
    cyc = 0; k = 0; prev_ack = 1'b0;
    for (int c = 0; c < 80 && k < 3; c++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (prev_ack) chk("b2b_ack_width", {31'd0, ack}, 32'd0);
      prev_ack = ack;
      if (ack) begin
        chk("b2b_ack_cycle", cyc, (k + 1) * LATENCY + k);
        chk("b2b_data", rdata, b2b_exp[k]);
        chk("b2b_err", {31'd0, err}, 32'd0);
        k++;
        if (k < 3) addr = b2b_addr[k];
        else req = 1'b0;
      end
    end
    chk("b2b_count", k, 3);
    @(negedge clk);
    chk("b2b_last_width", {31'd0, ack}, 32'd0);

    // Reset pulsed in the cycle after acceptance aborts a multi-cycle store
    @(negedge clk);
    we = 1'b1; addr = BASE + 32'h10; wdata = 32'h1111_1111; sel = 4'b1111; req = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0; req = 1'b0;
    #1;
    chk("abort_ack",   {31'd0, ack}, 32'd0);
    chk("abort_err",   {31'd0, err}, 32'd0);
    chk("abort_data",  rdata, 32'd0);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < LATENCY + 3; c++) begin
      @(negedge clk);
      chk("abort_no_ack", {31'd0, ack}, 32'd0);
    end
    access(1'b0, BASE + 32'h10, 32'h0, 4'b1111, d, e);
    chk("abort_reload", d, (LATENCY > 1) ? 32'hDEAD_AAEF : 32'h1111_1111);

    // Randomized traffic against a word-array model
    for (int unsigned i = 64; i < 80; i++) begin
      d = $urandom;
      ref_mem[i] = d;
      access(1'b1, BASE + 4 * i, d, 4'b1111, d, e);
      chk("preload_err", {31'd0, e}, 32'd0);
    end
    for (int n = 0; n < 60; n++) begin
      logic [31:0] r_addr, r_data, exp_d;
      logic [3:0]  r_sel;
      logic        r_we, exp_e;
      longint      a64;
      int unsigned kind, widx;
      kind   = $urandom_range(0, 9);
      r_we   = 1'($urandom_range(0, 1));
      r_data = $urandom;
      r_sel  = 4'($urandom_range(0, 15));
      if (kind < 8)       r_addr = BASE + 4 * $urandom_range(64, 79) + $urandom_range(0, 3);
      else if (kind == 8) r_addr = BASE - 4 * $urandom_range(1, 64) + $urandom_range(0, 3);
      else                r_addr = BASE + WIN + $urandom_range(0, 255);
      a64   = longint'(r_addr);
      exp_e = !(a64 >= longint'(BASE) && a64 < longint'(BASE) + longint'(WIN));
      widx  = (r_addr - BASE) / 4;
      exp_d = 32'h0;
      if (!exp_e && r_we) begin
        for (int b = 0; b < 4; b++)
          if (r_sel[b]) ref_mem[widx][8*b +: 8] = r_data[8*b +: 8];
      end else if (!exp_e) begin
        exp_d = ref_mem[widx];
      end
      access(r_we, r_addr, r_data, r_sel, d, e);
      chk("rand_err", {31'd0, e}, {31'd0, exp_e});
      if (exp_e || !r_we) chk("rand_data", d, exp_d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dbus_sram.md
# dbus_sram

Data-bus responder that sits on the far side of the load/store unit's dbus and services its requests from on-chip SRAM. It accepts one request at a time, applies a fixed, parameterised access latency and performs byte-lane-masked writes or full-word reads. It answers every request with a single-cycle acknowledge, plus an error flag for addresses outside its window. Byte extraction and sign extension stay in the LSU; this block always returns the full aligned word.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words, power of two.
- `BASE_ADDR`, 32'h8000_0000: byte address of word 0, aligned to `DEPTH_WORDS*4`.
- `LATENCY`, 2: cycles from request acceptance to acknowledge, 1..15.
- `clk  in  1`: the only clock; all state updates on its rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `dbus_req_i  in  1`: request valid; held with all fields stable until `dbus_ack_o`.
- `dbus_we_i  in  1`: 1 = store, 0 = load.
- `dbus_addr_i  in  32`: byte address; bits [1:0] are ignored for indexing.
- `dbus_data_i  in  32`: store data, already lane-aligned by the initiator.
- `dbus_sel_i  in  4`: byte-lane enables; bit k covers bits [8k+7:8k].
- `dbus_data_o  out  32`: read word.
- `dbus_ack_o  out  1`: one-cycle completion pulse.
- `dbus_err_o  out  1`: qualifies `dbus_ack_o`; 1 = request rejected.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - When `dbus_req_i`=1, latch we, word index, data, sel and a range-hit flag into request registers.
  - Load the latency counter with `LATENCY-1`.
  - Go to RESP if `LATENCY`=1, otherwise go to BUSY.
- BUSY: decrement the counter each cycle; go to RESP when it reaches 1.
- RESP:
  - Drive `dbus_ack_o`=1 for exactly this cycle, then return to IDLE.
- Range hit is `(addr - BASE_ADDR) < DEPTH_WORDS*4`, computed as unsigned 32-bit arithmetic. The word index is `(addr - BASE_ADDR) >> 2`, truncated to `$clog2(DEPTH_WORDS)` bits.
- Store:
  - The write commits at the clock edge that enters RESP.
  - Only lanes with a set `sel` bit are written; the other lanes keep their old value.
  - A store with `sel`=0 is acknowledged without error and writes nothing.
- Load:
  - The full word at the index is issued to the SRAM on the edge entering RESP and appears on `dbus_data_o` during RESP.
  - `dbus_data_o` holds that value until the next load completes.
  - `sel` is ignored for loads.
- Error (range miss):
  - `dbus_ack_o`=1 and `dbus_err_o`=1 in RESP.
  - No write is performed and `dbus_data_o` is forced to 0 for that ack.
- `dbus_err_o` is 0 whenever `dbus_ack_o` is 0.
- Changes on `dbus_req_i` or the request fields while in BUSY or RESP are ignored, because the latched copies are used.

## Timing
- Reset values: `dbus_ack_o`=0, `dbus_err_o`=0, `dbus_data_o`=0, FSM=IDLE, counter=0, request registers=0. SRAM contents are not reset.
- A request sampled in IDLE in cycle N is acknowledged in cycle N+`LATENCY`.
- Back-to-back requests: the initiator may keep `dbus_req_i` high after an ack for a new request. That request is sampled in the cycle after RESP, so throughput is one access per `LATENCY`+1 cycles.
- Reset asserted mid-BUSY aborts the access. No write commits, no ack is issued, and the FSM is in IDLE after release.
- Reset asserted during RESP leaves an already-committed write in memory.
- Read-after-write to the same word: the second access returns the new data.

## Structure
- Shared package `dbus_pkg`:
  - bus widths (addr 32, data 32, sel 4);
  - FSM state enum `{IDLE, BUSY, RESP}`;
  - `DBUS_SEL_W`=4.
- Sub-module `sram_bytewe`: single-port, synchronous read, 4 byte-lane write enables, `DEPTH_WORDS` entries.
- The top level holds the FSM, counter, request registers, range check and output registers.

## Test plan
- Reset, then store `0xDEADBEEF` with sel=`4'b1111` to `0x8000_0010`, then load the same address.
  - Ack at N+2 for each access, err=0.
  - The load returns `0xDEADBEEF`.
- Store `0x0000_AA00` with sel=`4'b0010` to `0x8000_0010`, then load.
  - The load returns `0xDEADAAEF`.
- Load from `0x7FFF_FFFC`, then store to `BASE_ADDR + DEPTH_WORDS*4`.
  - Both accesses get ack=1, err=1 and data_o=0.
  - A reload of the last valid word is unchanged.
- Hold `dbus_req_i` high for three consecutive loads with `LATENCY`=2.
  - Acks occur at cycles N+2, N+5 and N+8.
  - Each ack is exactly one cycle wide.
- Store issued, then `rst_n` pulsed low in cycle N+1 (during BUSY).
  - No ack is issued and outputs reach their reset values.
  - A reload after reset shows the old word.
- Rebuild with `LATENCY`=1 and `LATENCY`=15.
  - Ack latency is exactly 1 and 15 cycles respectively.
  - Data is correct in both builds.
